// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiply unit.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M into A, then arithmetic
// shift of {A, Q, q_-1} right by one bit. Purely combinational.
module booth_step #(
  parameter int E = 33
) (
  input  logic [2*E:0] acc_i,
  input  logic [E-1:0] m_i,
  output logic [2*E:0] acc_o
);

  logic [E-1:0] a_cur;
  logic [E-1:0] a_sum;

  // Recode {Q[0], q_-1}, update A (carry dropped), then shift right arithmetically.
  always_comb begin
    a_cur = acc_i[2*E:E+1];
    case (acc_i[1:0])
      2'b01:   a_sum = a_cur + m_i;
      2'b10:   a_sum = a_cur - m_i;
      default: a_sum = a_cur;
    endcase
    acc_o = {a_sum[E-1], a_sum, acc_i[E:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/ready/busy/done handshake.
// Operands are widened by one bit (sign- or zero-extended) so that signed and
// unsigned multiplies share the same Booth datapath; E = WIDTH+1 iterations.
//
// state | meaning
// IDLE  | waiting for start, product held
// LOAD  | capture extended operands, clear accumulator and counter
// RUN   | one Booth step per cycle, E cycles
// DONE  | product registered, done pulse; start here chains the next op
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int E  = WIDTH + 1;
  localparam int AW = 2 * E + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(E - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [E-1:0]       m_q, m_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [AW-1:0]      step_acc;
  logic [E-1:0]       ext_a;
  logic [E-1:0]       ext_b;

  assign ext_a = {(signed_mode == MODE_SIGNED) & op_a[WIDTH-1], op_a};
  assign ext_b = {(signed_mode == MODE_SIGNED) & op_b[WIDTH-1], op_b};

  booth_step #(
    .E (E)
  ) u_step (
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (step_acc)
  );

  // State, counter, datapath and product registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      prod_q  <= prod_d;
    end
  end

  // Next-state and datapath control; everything holds unless a state updates it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        m_d     = ext_a;
        acc_d   = {{E{1'b0}}, ext_b, 1'b0};
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final step: product is the low 2*WIDTH bits of {A, Q}.
          prod_d  = step_acc[2*WIDTH:1];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready   = (state_q == IDLE) || (state_q == DONE);
  assign busy    = (state_q == LOAD) || (state_q == RUN);
  assign done    = (state_q == DONE);
  assign prod_hi = prod_q[2*WIDTH-1:WIDTH];
  assign prod_lo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: a 32-bit and an 8-bit instance, scoreboard of
// expected products checked on every done pulse, plus handshake/reset cases.
module tb_booth_mult_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        st32, sg32, rdy32, bsy32, dn32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        st8, sg8, rdy8, bsy8, dn8;
  logic [7:0]  a8, b8, hi8, lo8;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int dcnt32 = 0;
  int dcnt8 = 0;

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec32_t;

  typedef struct {
    bit          sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec8_t;

  exp_t   q32[$];
  exp_t   q8[$];
  exp_t   e32, e8;
  vec32_t v32[5];
  vec8_t  v8[6];

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .start(st32), .signed_mode(sg32),
    .op_a(a32), .op_b(b32), .ready(rdy32), .busy(bsy32), .done(dn32),
    .prod_hi(hi32), .prod_lo(lo32)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(st8), .signed_mode(sg8),
    .op_a(a8), .op_b(b8), .ready(rdy8), .busy(bsy8), .done(dn8),
    .prod_hi(hi8), .prod_lo(lo8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumers: each done pulse pops one expectation.
  always @(negedge clock) begin
    if (dn32 === 1'b1) begin
      dcnt32++;
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32_unexpected: got done with empty scoreboard, expected no done");
      end else begin
        e32 = q32.pop_front();
        chk("prod32", {hi32, lo32}, e32.prod);
        chk("latency32", 64'(cyc - e32.acc_cyc), 64'd34);
      end
    end
  end

  always @(negedge clock) begin
    if (dn8 === 1'b1) begin
      dcnt8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done with empty scoreboard, expected no done");
      end else begin
        e8 = q8.pop_front();
        chk("prod8", {48'd0, hi8, lo8}, e8.prod);
        chk("latency8", 64'(cyc - e8.acc_cyc), 64'd10);
      end
    end
  end

  task automatic issue32(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input bit push);
    exp_t e;
    @(negedge clock);
    sg32 = sgn; a32 = a; b32 = b; st32 = 1'b1;
    chk("ready32_idle", {63'd0, rdy32}, 64'd1);
    @(posedge clock);
    #1;
    e.prod = prod;
    e.acc_cyc = cyc;
    if (push) q32.push_back(e);
    @(negedge clock);
    st32 = 1'b0;
    chk("busy32_load", {63'd0, bsy32}, 64'd1);
    chk("ready32_load", {63'd0, rdy32}, 64'd0);
  endtask

  task automatic issue8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] prod);
    exp_t e;
    @(negedge clock);
    sg8 = sgn; a8 = a; b8 = b; st8 = 1'b1;
    @(posedge clock);
    #1;
    e.prod = {48'd0, prod};
    e.acc_cyc = cyc;
    q8.push_back(e);
    @(negedge clock);
    st8 = 1'b0;
  endtask

  task automatic wait_done32(input int n_before);
    int k = 0;
    while (dcnt32 == n_before && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (dcnt32 == n_before) begin
      checks++;
      errors++;
      $display("FAIL timeout32: got no done in 200 cycles, expected one");
    end
  endtask

  task automatic wait_done8(input int n_before);
    int k = 0;
    while (dcnt8 == n_before && k < 100) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (dcnt8 == n_before) begin
      checks++;
      errors++;
      $display("FAIL timeout8: got no done in 100 cycles, expected one");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    logic [31:0] ra, rb;
    logic [63:0] sa, sb, mp;
    logic [15:0] sa8, sb8, mp8;

    v32[0] = '{1'b1, 32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
    v32[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    v32[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    v32[3] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    v32[4] = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};

    v8[0] = '{1'b0, 8'd200, 8'd100, 16'h4E20};
    v8[1] = '{1'b1, 8'h80,  8'hFF,  16'h0080};
    v8[2] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    v8[3] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    v8[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    v8[5] = '{1'b1, 8'h7F,  8'h80,  16'hC080};

    st32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
    st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;

    // Reset state.
    #1;
    chk("rst_ready32", {63'd0, rdy32}, 64'd1);
    chk("rst_busy32", {63'd0, bsy32}, 64'd0);
    chk("rst_done32", {63'd0, dn32}, 64'd0);
    chk("rst_prod32", {hi32, lo32}, 64'd0);
    chk("rst_prod8", {48'd0, hi8, lo8}, 64'd0);
    chk("rst_ready8", {63'd0, rdy8}, 64'd1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Table vectors, 32-bit.
    foreach (v32[i]) begin
      n = dcnt32;
      issue32(v32[i].sgn, v32[i].a, v32[i].b, v32[i].prod, 1'b1);
      wait_done32(n);
    end

    // Random operands against an independent wide-multiply model.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) begin
        sa = {{32{ra[31]}}, ra};
        sb = {{32{rb[31]}}, rb};
      end else begin
        sa = {32'd0, ra};
        sb = {32'd0, rb};
      end
      mp = sa * sb;
      n = dcnt32;
      issue32(i[0], ra, rb, mp, 1'b1);
      wait_done32(n);
    end

    // Table vectors and random operands, 8-bit.
    foreach (v8[i]) begin
      n = dcnt8;
      issue8(v8[i].sgn, v8[i].a, v8[i].b, v8[i].prod);
      wait_done8(n);
    end
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa8 = i[0] ? {{8{ra[7]}}, ra[7:0]} : {8'd0, ra[7:0]};
      sb8 = i[0] ? {{8{rb[7]}}, rb[7:0]} : {8'd0, rb[7:0]};
      mp8 = sa8 * sb8;
      n = dcnt8;
      issue8(i[0], ra[7:0], rb[7:0], mp8);
      wait_done8(n);
    end

    // start pulsed mid-RUN is ignored: exactly one done.
    n = dcnt32;
    issue32(1'b0, 32'd3, 32'd4, 64'd12, 1'b1);
    repeat (5) @(negedge clock);
    st32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    chk("busy32_run", {63'd0, bsy32}, 64'd1);
    chk("ready32_run", {63'd0, rdy32}, 64'd0);
    @(negedge clock);
    st32 = 1'b0;
    wait_done32(n);
    repeat (40) @(negedge clock);
    chk("single_done", 64'(dcnt32 - n), 64'd1);

    // start held through DONE: back-to-back, product holds first result.
    n = dcnt32;
    @(negedge clock);
    sg32 = 1'b0; a32 = 32'd7; b32 = 32'd6; st32 = 1'b1;
    @(posedge clock);
    #1;
    e.prod = 64'd42;
    e.acc_cyc = cyc;
    q32.push_back(e);
    repeat (2) @(negedge clock);
    a32 = 32'd11; b32 = 32'd13;
    wait_done32(n);
    e.prod = 64'd143;
    e.acc_cyc = cyc + 1;
    q32.push_back(e);
    @(negedge clock);
    st32 = 1'b0;
    chk("b2b_busy", {63'd0, bsy32}, 64'd1);
    chk("b2b_done_pulse", {63'd0, dn32}, 64'd0);
    chk("b2b_hold_a", {hi32, lo32}, 64'd42);
    repeat (15) @(negedge clock);
    chk("b2b_hold_b", {hi32, lo32}, 64'd42);
    wait_done32(n + 1);
    chk("b2b_count", 64'(dcnt32 - n), 64'd2);

    // Asynchronous reset at RUN counter=10: outputs clear at once, no done.
    n = dcnt32;
    issue32(1'b0, 32'd100, 32'd3, 64'd300, 1'b0);
    @(posedge clock);
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", {63'd0, rdy32}, 64'd1);
    chk("arst_busy", {63'd0, bsy32}, 64'd0);
    chk("arst_done", {63'd0, dn32}, 64'd0);
    chk("arst_prod", {hi32, lo32}, 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("arst_no_done", 64'(dcnt32 - n), 64'd0);
    issue32(1'b0, 32'd5, 32'd6, 64'd30, 1'b1);
    wait_done32(n);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 64'(q32.size() + q8.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
